dcache_tag_bank: RTL
====================

DCACHE_TAG_BANK -- requirements
Module: dcache_tag_bank

Interface
Parameters:
REQ-001 NR_WAYS, 4, number of ways, each a single-port bank.
REQ-002 DEPTH, 256, entries per way; a power of two.
REQ-003 TAG_WIDTH, 20, tag field width.
REQ-004 DATA_WIDTH, 64, data field width.
REQ-005 ADDR_WIDTH, 64, request address width.
REQ-006 INDEX_LSB, 3, lowest address bit of the set index.

Ports:
REQ-007 clk_i  in  1  single clock; all logic on the rising edge.
REQ-008 rst_ni  in  1  asynchronous, active-low reset.
REQ-009 req_i  in  NR_WAYS  per-way access request; several bits may be set at once.
REQ-010 addr_i  in  ADDR_WIDTH  shared address; index = addr_i[INDEX_LSB +: log2(DEPTH)].
REQ-011 we_i  in  1  1 = write, 0 = read; applies to every way in req_i.
REQ-012 wdata_i  in  TAG_WIDTH+DATA_WIDTH+2  entry to write, laid out MSB..LSB as {tag, data, valid, dirty}.
REQ-013 be_i  in  ceil(TAG_WIDTH/8)+ceil(DATA_WIDTH/8)+NR_WAYS  write enables, laid out MSB..LSB as {tag byte enables, data byte enables, vldrty[NR_WAYS]}.
REQ-014 flush_i  in  1  single-cycle pulse; invalidates the whole array.
REQ-015 rdata_o  out  NR_WAYS*(TAG_WIDTH+DATA_WIDTH+2)  per-way read entry; way j occupies slice j.
REQ-016 busy_o  out  1  high while the init/flush sweep runs; requests are ignored while it is high.

Function
REQ-017 States SHALL be INIT and IDLE; reset SHALL enter INIT with the sweep index at 0.
REQ-018 INIT: each cycle, every way SHALL write valid=0 and dirty=0 at the sweep index and leave tag and data unchanged; the index then increments by 1.
REQ-019 INIT: after the cycle that writes index DEPTH-1, the state SHALL go to IDLE; a full sweep takes exactly DEPTH cycles.
REQ-020 busy_o SHALL be 1 in INIT and 0 in IDLE; it is registered.
REQ-021 IDLE with flush_i=1: the state SHALL go to INIT with index 0; any req_i in that cycle is dropped, with no write and no rdata_o update.
REQ-022 INIT with flush_i=1: the sweep SHALL restart at index 0.
REQ-023 INIT: req_i SHALL be ignored and no bank access SHALL occur.
REQ-024 IDLE read (req_i[j]=1, we_i=0): rdata_o slice j SHALL present the entry at that index on the next cycle; read latency is exactly 1.
REQ-025 Any rdata_o slice not read in a cycle SHALL hold its previous value.
REQ-026 IDLE write (req_i[j]=1, we_i=1): each tag byte SHALL be written only where its tag byte enable is set, and each data byte only where its data byte enable is set.
REQ-027 The valid and dirty bits of way j SHALL be written only when vldrty[j]=1.
REQ-028 A write cycle SHALL leave rdata_o slice j unchanged.
REQ-029 When TAG_WIDTH or DATA_WIDTH is not a multiple of 8, the top byte enable SHALL cover only the remaining bits.
REQ-030 Address bits outside the index field SHALL be ignored.
REQ-031 Back-to-back accesses on consecutive cycles SHALL be supported in IDLE with no bubble.
REQ-032 A write followed by a read of the same index on the next cycle SHALL return the newly written value.

Reset
REQ-033 Reset SHALL asynchronously force: state=INIT, sweep index=0, busy_o=1, rdata_o all zero.
REQ-034 Array contents SHALL NOT be reset; only the INIT sweep clears valid/dirty.
REQ-035 Reset asserted mid-sweep or mid-access SHALL abort the sweep or access and restart from index 0.

Structure
REQ-036 The entry layout, the byte-enable layout, and their width functions SHALL live in the shared cache package, alongside the tag-compare arbiter's types.
REQ-037 One sub-module, tag_bank_sram, SHALL implement a single-port, byte-enabled, 1-cycle-latency way bank; NR_WAYS copies are instantiated.
REQ-038 The INIT/IDLE FSM and the sweep counter SHALL live in the top level.

Verification
REQ-039 Reset released -> busy_o=1 for exactly 256 cycles, then 0; a read of every index in every way returns valid=0, dirty=0.
REQ-040 Write way 2 at index 0x15 with tag=0xABCDE, data=0x1122334455667788, valid=1, and all enables set; read on the next cycle -> rdata_o slice 2 equals that entry, and slices 0, 1, 3 are unchanged.
REQ-041 Partial write: data enables = 0x0F with data 0xFFFFFFFFFFFFFFFF over 0x1122334455667788 -> readback data is 0x11223344FFFFFFFF, and tag/valid are unchanged when their enables are 0.
REQ-042 flush_i pulsed in the same cycle as a write request -> the write is dropped, busy_o=1 on the next cycle for 256 cycles, and every entry then reads valid=0.
REQ-043 flush_i pulsed again at sweep index 100 -> busy_o stays high for a further 256 cycles from the restart.
REQ-044 rst_ni asserted mid-read -> rdata_o=0 immediately (asynchronously), then a full 256-cycle sweep follows.

Source files
------------

// File: rtl/dcache_tag_bank_pkg.sv
// Shared data-cache package.
// Holds the tag-bank entry layout {tag, data, valid, dirty}, the write-enable
// layout {tag byte enables, data byte enables, vldrty[ways]}, the width
// helpers for both, the tag-bank sweep FSM states and the tag-compare
// arbiter's types.
package dcache_tag_bank_pkg;

  // Tag-bank controller states
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } tag_state_e;

  // Entry layout, LSB upwards: dirty, valid, data, tag
  localparam int unsigned ENT_DIRTY_BIT = 32'd0;
  localparam int unsigned ENT_VALID_BIT = 32'd1;
  localparam int unsigned ENT_DATA_LSB  = 32'd2;

  // Number of byte enables covering a field; the top one may be partial
  function automatic int unsigned byte_count(input int unsigned w);
    return (w + 32'd7) / 32'd8;
  endfunction

  function automatic int unsigned entry_width(input int unsigned tag_w,
                                              input int unsigned data_w);
    return tag_w + data_w + 32'd2;
  endfunction

  function automatic int unsigned be_width(input int unsigned tag_w,
                                           input int unsigned data_w,
                                           input int unsigned ways);
    return byte_count(tag_w) + byte_count(data_w) + ways;
  endfunction

  // Tag-compare arbiter types
  typedef enum logic [1:0] {
    ARB_FIXED       = 2'd0,
    ARB_ROUND_ROBIN = 2'd1
  } tag_arb_policy_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] way;
  } tag_cmp_result_t;

endpackage

// File: rtl/dcache_tag_bank_sram.sv
// tag_bank_sram: one single-port way bank with byte-granular write enables.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset (read register only)
//   req_i, we_i     access strobe, 1 = write / 0 = read
//   index_i         entry index
//   wdata_i         entry {tag, data, valid, dirty}
//   tag_be_i        tag byte enables (top enable covers the leftover bits)
//   data_be_i       data byte enables
//   vldrty_we_i     write enable for the valid and dirty bits
//   rdata_o         read entry, 1-cycle latency, holds when not read
module tag_bank_sram
  import dcache_tag_bank_pkg::*;
#(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned TAG_WIDTH  = 20,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         req_i,
  input  logic                                         we_i,
  input  logic [$clog2(DEPTH)-1:0]                     index_i,
  input  logic [entry_width(TAG_WIDTH, DATA_WIDTH)-1:0] wdata_i,
  input  logic [byte_count(TAG_WIDTH)-1:0]             tag_be_i,
  input  logic [byte_count(DATA_WIDTH)-1:0]            data_be_i,
  input  logic                                         vldrty_we_i,
  output logic [entry_width(TAG_WIDTH, DATA_WIDTH)-1:0] rdata_o
);

  localparam int unsigned EW      = entry_width(TAG_WIDTH, DATA_WIDTH);
  localparam int unsigned TAG_LSB = ENT_DATA_LSB + DATA_WIDTH;

  logic [EW-1:0] mem_r [DEPTH];
  logic [EW-1:0] bit_we_s;
  logic [EW-1:0] rdata_r;

  // Expand the byte enables to one enable per entry bit
  assign bit_we_s[ENT_DIRTY_BIT] = vldrty_we_i;
  assign bit_we_s[ENT_VALID_BIT] = vldrty_we_i;

  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_data_we
    assign bit_we_s[ENT_DATA_LSB + b] = data_be_i[b / 8];
  end

  for (genvar b = 0; b < TAG_WIDTH; b++) begin : g_tag_we
    assign bit_we_s[TAG_LSB + b] = tag_be_i[b / 8];
  end

  // Array write; contents are deliberately left unreset
  always_ff @(posedge clk_i) begin
    if (req_i && we_i) begin
      mem_r[index_i] <= (mem_r[index_i] & ~bit_we_s) | (wdata_i & bit_we_s);
    end
  end

  // Read register: loads only on a read, otherwise holds
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_r <= '0;
    end else if (req_i && !we_i) begin
      rdata_r <= mem_r[index_i];
    end
  end

  assign rdata_o = rdata_r;

endmodule

// File: rtl/dcache_tag_bank.sv
// dcache_tag_bank: NR_WAYS single-port tag/data way banks sharing one address,
// plus the INIT/IDLE controller that sweeps valid/dirty to zero after reset
// and after every flush.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   req_i          per-way access request
//   addr_i         shared address, index = addr_i[INDEX_LSB +: log2(DEPTH)]
//   we_i           1 = write, 0 = read, for every requested way
//   wdata_i        entry {tag, data, valid, dirty}
//   be_i           {tag byte enables, data byte enables, vldrty[NR_WAYS]}
//   flush_i        one-cycle pulse, invalidates the whole array
//   rdata_o        per-way read entry, way j in slice j
//   busy_o         high while the sweep runs; requests are ignored then
module dcache_tag_bank
  import dcache_tag_bank_pkg::*;
#(
  parameter int unsigned NR_WAYS    = 4,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned TAG_WIDTH  = 20,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned INDEX_LSB  = 3
) (
  input  logic                                                 clk_i,
  input  logic                                                 rst_ni,
  input  logic [NR_WAYS-1:0]                                   req_i,
  input  logic [ADDR_WIDTH-1:0]                                addr_i,
  input  logic                                                 we_i,
  input  logic [entry_width(TAG_WIDTH, DATA_WIDTH)-1:0]         wdata_i,
  input  logic [be_width(TAG_WIDTH, DATA_WIDTH, NR_WAYS)-1:0]   be_i,
  input  logic                                                 flush_i,
  output logic [NR_WAYS*entry_width(TAG_WIDTH, DATA_WIDTH)-1:0] rdata_o,
  output logic                                                 busy_o
);

  localparam int unsigned EW         = entry_width(TAG_WIDTH, DATA_WIDTH);
  localparam int unsigned IDX_W      = $clog2(DEPTH);
  localparam int unsigned TAG_BYTES  = byte_count(TAG_WIDTH);
  localparam int unsigned DATA_BYTES = byte_count(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 32'd1);

  tag_state_e              state_r;
  tag_state_e              state_s;
  logic [IDX_W-1:0]        idx_r;
  logic [IDX_W-1:0]        idx_s;
  logic                    busy_r;

  logic [NR_WAYS-1:0]      bank_req_s;
  logic [NR_WAYS-1:0]      bank_vd_we_s;
  logic                    bank_we_s;
  logic [IDX_W-1:0]        bank_idx_s;
  logic [EW-1:0]           bank_wdata_s;
  logic [TAG_BYTES-1:0]    bank_tag_be_s;
  logic [DATA_BYTES-1:0]   bank_data_be_s;

  // Only the index field of the address matters; the rest is folded away
  logic                    unused_addr_s;
  assign unused_addr_s = ^addr_i;

  // Next state, sweep index and bank access selection
  always_comb begin
    state_s        = state_r;
    idx_s          = idx_r;
    bank_req_s     = '0;
    bank_we_s      = 1'b0;
    bank_idx_s     = idx_r;
    bank_wdata_s   = '0;
    bank_tag_be_s  = '0;
    bank_data_be_s = '0;
    bank_vd_we_s   = '0;
    case (state_r)
      ST_INIT: begin
        // Zero wdata with only vldrty enabled: clears valid/dirty, keeps tag/data
        bank_req_s   = '1;
        bank_we_s    = 1'b1;
        bank_vd_we_s = '1;
        if (flush_i) begin
          idx_s = '0;
        end else if (idx_r == LAST_IDX) begin
          state_s = ST_IDLE;
          idx_s   = '0;
        end else begin
          idx_s = idx_r + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        if (flush_i) begin
          // Any request in the flush cycle is dropped
          state_s = ST_INIT;
          idx_s   = '0;
        end else begin
          bank_req_s     = req_i;
          bank_we_s      = we_i;
          bank_idx_s     = addr_i[INDEX_LSB +: IDX_W];
          bank_wdata_s   = wdata_i;
          bank_tag_be_s  = be_i[NR_WAYS + DATA_BYTES +: TAG_BYTES];
          bank_data_be_s = be_i[NR_WAYS +: DATA_BYTES];
          bank_vd_we_s   = be_i[NR_WAYS-1:0];
        end
      end
      default: begin
        state_s = ST_INIT;
        idx_s   = '0;
      end
    endcase
  end

  // Controller state, sweep index and registered busy flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_INIT;
      idx_r   <= '0;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      busy_r  <= (state_s == ST_INIT);
    end
  end

  assign busy_o = busy_r;

  for (genvar j = 0; j < NR_WAYS; j++) begin : g_way
    tag_bank_sram #(
      .DEPTH      (DEPTH),
      .TAG_WIDTH  (TAG_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_i       (bank_req_s[j]),
      .we_i        (bank_we_s),
      .index_i     (bank_idx_s),
      .wdata_i     (bank_wdata_s),
      .tag_be_i    (bank_tag_be_s),
      .data_be_i   (bank_data_be_s),
      .vldrty_we_i (bank_vd_we_s[j]),
      .rdata_o     (rdata_o[j*EW +: EW])
    );
  end

endmodule
